mdu_seq: RTL and testbench

- Iterative multiply/divide sequencer for the single-cycle MIPS core.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and owns the HI/LO registers.
- Drives a combinational stall that the core ANDs into the PC register enable. This holds the current instruction on the bus until the result is committed.
- Also services MTHI/MTLO writes. HI/LO are read combinationally for MFHI/MFLO.

---
 rtl/mdu_seq.sv | 140 ++++++++++++++
 tb/tb_mdu_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Iterative multiply/divide sequencer owning HI/LO: radix-2 shift-add multiply,
// restoring divide, sign fix-up in a final cycle, combinational PC stall.
module mdu_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state_q, state_d;
   logic               div_q, div_d;
   logic               sa_q, sa_d, sb_q, sb_d;
   logic [WIDTH-1:0]   mb_q, mb_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d;

   logic               accept, sa_in, sb_in;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH:0]     mul_sum, div_sh, div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   rem_new;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign accept = (state_q == IDLE) && start && !done_q;
   assign sa_in  = op[0] & a[WIDTH-1];
   assign sb_in  = op[0] & b[WIDTH-1];
   assign abs_a  = sa_in ? -a : a;
   assign abs_b  = sb_in ? -b : b;

   // Multiply: acc = {partial product, remaining multiplier bits}
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mb_q} : '0);
   // Divide: acc = {remainder, dividend bits shifting into quotient}
   assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, mb_q};
   assign div_ge   = div_sh >= {1'b0, mb_q};
   assign rem_new  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];

   // A zero divisor leaves the remainder equal to |a|, so the sign fix restores a itself
   assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
   assign quo_fix  = (mb_q == '0) ? '1 :
                     ((sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
   assign rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      mb_d    = mb_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               div_d   = op[1];
               sa_d    = sa_in;
               sb_d    = sb_in;
               mb_d    = op[1] ? abs_b : abs_a;
               acc_d   = {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
               cnt_d   = CNT_W'(WIDTH);
               state_d = CALC;
            end else begin
               if (mthi) hi_d = a;
               if (mtlo) lo_d = a;
            end
         end
         CALC: begin
            acc_d = div_q ? {rem_new, acc_q[WIDTH-2:0], div_ge}
                          : {mul_sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = FIX;
         end
         FIX: begin
            if (div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         div_q   <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         mb_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         mb_q    <= mb_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign hi    = hi_q;
   assign lo    = lo_q;
   assign busy  = (state_q != IDLE);
   assign done  = done_q;
   assign stall = (start & ~busy & ~done_q) | busy;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed, table-driven bench for mdu_seq: result values, stall length, done pulse,
// HI/LO hold during operation, MTHI/MTLO rules and asynchronous abort.
module tb_mdu_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        mthi, mtlo;
   logic [31:0] hi, lo;
   logic        busy, done, stall;

   int n_chk  = 0;
   int n_fail = 0;

   mdu_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo),
      .busy(busy), .done(done), .stall(stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called just after a falling edge; returns one cycle after the done cycle.
   task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic [31:0] phi, input logic [31:0] plo,
                         input int mt_at, input int id);
      int k = 0;
      int stall_cnt = 0;
      bit held = 1'b1;
      start = 1'b1; op = o; a = av; b = bv;
      forever begin
         mthi = (k == mt_at);
         mtlo = (k == mt_at);
         if (k == mt_at && k > 0) begin
            a = 32'hDEADBEEF; b = 32'h0; op = ~o;
         end
         #1;
         if (done) break;
         if (stall) stall_cnt++;
         if (hi !== phi || lo !== plo) held = 1'b0;
         if (k > 60) break;
         @(negedge clk);
         k++;
      end
      mthi = 1'b0; mtlo = 1'b0;
      chk($sformatf("op%0d done", id), 64'(done), 64'(1));
      chk($sformatf("op%0d stall_in_done", id), 64'(stall), 64'(0));
      chk($sformatf("op%0d stall_cycles", id), 64'(stall_cnt), 64'(34));
      chk($sformatf("op%0d hi", id), 64'(hi), 64'(ehi));
      chk($sformatf("op%0d lo", id), 64'(lo), 64'(elo));
      chk($sformatf("op%0d hilo_held", id), 64'(held), 64'(1));
      @(negedge clk);
      #1;
      chk($sformatf("op%0d done_once", id), 64'(done), 64'(0));
      chk($sformatf("op%0d no_restart", id), 64'(busy), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] phi, plo;
      bit quiet;

      tbl[0] = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
      tbl[1] = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      tbl[2] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      tbl[3] = '{2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
      tbl[4] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      tbl[5] = '{2'b10, 32'd10,       32'd3,        32'd1,        32'd3};
      tbl[6] = '{2'b00, 32'd3,        32'd4,        32'd0,        32'd12};
      tbl[7] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      tbl[8] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};
      tbl[9] = '{2'b11, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};

      rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; mthi = 1'b0; mtlo = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset hi", 64'(hi), 64'(0));
      chk("reset lo", 64'(lo), 64'(0));
      chk("reset busy", 64'(busy), 64'(0));
      chk("reset done", 64'(done), 64'(0));
      chk("reset stall_idle", 64'(stall), 64'(0));
      start = 1'b1;
      #1;
      chk("reset stall_start", 64'(stall), 64'(1));
      start = 1'b0;
      rst = 1'b1;
      @(negedge clk);

      // Back-to-back instructions straight from the table
      phi = '0; plo = '0;
      for (int i = 0; i < 10; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, phi, plo, -1, i);
         phi = tbl[i].hi;
         plo = tbl[i].lo;
      end
      start = 1'b0;

      @(negedge clk);
      mthi = 1'b1; mtlo = 1'b1; a = 32'hA5A5A5A5;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b0;
      #1;
      chk("mt hi", 64'(hi), 64'(32'hA5A5A5A5));
      chk("mt lo", 64'(lo), 64'(32'hA5A5A5A5));

      // mthi/mtlo plus operand scrambling while busy
      run_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 32'hA5A5A5A5, 32'hA5A5A5A5, 5, 20);
      // mthi/mtlo in the accepting cycle lose to start
      run_op(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 32'd2, 32'd14, 0, 21);

      start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
      for (int k = 0; k < 10; k++) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort busy", 64'(busy), 64'(0));
      chk("abort done", 64'(done), 64'(0));
      chk("abort hi", 64'(hi), 64'(0));
      chk("abort lo", 64'(lo), 64'(0));
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      quiet = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         #1;
         if (done || busy || hi !== '0 || lo !== '0) quiet = 1'b0;
      end
      chk("abort no_commit", 64'(quiet), 64'(1));
      run_op(2'b00, 32'd7, 32'd9, 32'd0, 32'd63, 32'd0, 32'd0, -1, 22);
      start = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
